sweep_controller: RTL and testbench
===================================

# sweep_controller

Frequency-sweep sequencer that drives the `phase_step` input of the waveform generator's phase accumulator. On a start command it latches a sweep description and steps the tuning word from a start to a stop value at a programmable dwell rate. It supports single, repeating and ping-pong (triangle) sweeps. It sits between the control/register logic and the phase accumulator, and is the only writer of `phase_step`.

## Interface
- STEP_W, 10, width of tuning word (matches phase accumulator phase_step)
- DWELL_W, 16, width of dwell count
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- start  in  1  sweep start request, sampled only in IDLE
- abort  in  1  terminate sweep, effective in any state
- mode  in  2  00 single, 01 repeat, 10 ping-pong, 11 reserved (treated as single)
- f_start  in  STEP_W  first tuning word
- f_stop  in  STEP_W  last tuning word (inclusive)
- f_inc  in  STEP_W  increment per step
- dwell  in  DWELL_W  extra hold cycles per value (each value is held for dwell+1 cycles)
- phase_step  out  STEP_W  tuning word to phase accumulator; 0 when not busy
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on normal completion of a single sweep
- wrap  out  1  one-cycle pulse on each repeat restart or ping-pong turnaround
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, RUN_UP, RUN_DOWN.
- Reset values: state IDLE; phase_step 0; busy, done, wrap and err all 0; dwell counter 0.
- Start in IDLE:
  - All of mode, f_start, f_stop, f_inc and dwell are latched into internal registers. Later changes to these inputs have no effect until the next start.
  - Reject (err pulse, stay IDLE) if f_start > f_stop, or if f_inc == 0 and f_start != f_stop.
  - Otherwise go to RUN_UP with phase_step = f_start.
- Hold: each value is held while the dwell counter runs 0..dwell. The counter clears on every value change.
- RUN_UP step, when cur == f_stop:
  - single: go to IDLE, phase_step 0, done pulse.
  - repeat: next = f_start, wrap pulse.
  - ping-pong: go to RUN_DOWN with next = max(f_stop - f_inc, f_start), wrap pulse.
- RUN_UP step, otherwise: next = min(cur + f_inc, f_stop). The sum is computed at STEP_W+1 bits, so there is no modular wrap and f_stop is always emitted exactly.
- RUN_DOWN step:
  - When cur == f_start: go to RUN_UP with next = min(f_start + f_inc, f_stop), wrap pulse.
  - Otherwise: next = max(cur - f_inc, f_start), computed without underflow.
- Degenerate case f_start == f_stop:
  - single: the value is held dwell+1 cycles, then done.
  - repeat and ping-pong: the value is held constant, with a wrap pulse every dwell+1 cycles.
- Abort in RUN_*: next cycle IDLE, phase_step 0, busy 0, no done and no wrap.
- Abort and start in the same IDLE cycle: abort wins, no sweep and no err.
- Start while busy is ignored.
- Reset mid-sweep returns all outputs to their reset values on the next edge.

## Timing
- Start sampled at edge N: phase_step = f_start, busy = 1 from cycle N+1. err, if raised, is valid in cycle N+1 only.
- Value k appears at cycle N+1 + k*(dwell+1).
- wrap is asserted in the first cycle the post-restart or post-turnaround value is on phase_step.
- Single completion: the last value (f_stop) is held through cycle L. In cycle L+1, busy = 0, phase_step = 0 and done = 1. A new start is accepted at edge L+1.
- done, wrap and err are each exactly one cycle wide and are mutually exclusive.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single sweep: f_start=100, f_stop=130, f_inc=10, dwell=2, start at N -> phase_step holds 100 for N+1..N+3, 110 for N+4..N+6, 120 for N+7..N+9, 130 for N+10..N+12; then in cycle N+13, done=1, busy=0, phase_step=0.
- Clamp: f_start=100, f_stop=125, f_inc=10, dwell=0, single -> phase_step sequence 100, 110, 120, 125, then done.
- Ping-pong: f_start=10, f_stop=30, f_inc=10, dwell=0 -> sequence 10, 20, 30, 20(wrap), 10, 20(wrap), 30, ... continuing until abort. Abort -> phase_step=0, busy=0 the next cycle, no done.
- Repeat: f_start=5, f_stop=7, f_inc=1, dwell=1 -> sequence 5, 5, 6, 6, 7, 7, 5(wrap), 5, ... Changing f_stop mid-sweep has no effect.
- Rejects and conflicts:
  - f_start=50, f_stop=40 -> err pulse at N+1, busy stays 0.
  - f_inc=0 with f_start=10, f_stop=20 -> err pulse, busy stays 0.
  - start and abort in the same cycle -> nothing happens.
  - start while busy -> ignored.
- Reset at cycle N+5 of a running sweep -> all outputs 0 at N+6. A new start then works normally.

Source files
------------

// File: rtl/sweep_controller.sv
// Frequency-sweep sequencer: steps the phase accumulator tuning word from a start to a stop value
// with a programmable dwell, in single, repeat or ping-pong (triangle) mode.
module sweep_controller #(
   parameter int unsigned STEP_W  = 10,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [1:0]         i_mode,
   input  logic [STEP_W-1:0]  i_f_start,
   input  logic [STEP_W-1:0]  i_f_stop,
   input  logic [STEP_W-1:0]  i_f_inc,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [STEP_W-1:0]  o_phase_step,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_wrap,
   output logic               o_err
);

   typedef enum logic [1:0] {StIdle, StRunUp, StRunDown} state_e;

   localparam logic [1:0] ModeRepeat   = 2'b01;
   localparam logic [1:0] ModePingPong = 2'b10;

   state_e             r_state, w_state_d;
   logic [STEP_W-1:0]  r_cur, w_cur_d;
   logic [DWELL_W-1:0] r_cnt, w_cnt_d;
   logic [1:0]         r_mode, w_mode_d;
   logic [STEP_W-1:0]  r_start, w_start_d;
   logic [STEP_W-1:0]  r_stop, w_stop_d;
   logic [STEP_W-1:0]  r_inc, w_inc_d;
   logic [DWELL_W-1:0] r_dwell, w_dwell_d;
   logic               r_busy, r_done, r_wrap, r_err;
   logic               w_done_d, w_wrap_d, w_err_d;

   // Step arithmetic at STEP_W+1 bits so the upward sum never wraps modulo 2^STEP_W.
   logic [STEP_W:0]    w_sum_cur, w_sum_start;
   logic [STEP_W-1:0]  w_up_next, w_dn_next, w_turn_dn, w_turn_up;

   assign w_sum_cur   = {1'b0, r_cur} + {1'b0, r_inc};
   assign w_sum_start = {1'b0, r_start} + {1'b0, r_inc};
   assign w_up_next   = (w_sum_cur > {1'b0, r_stop}) ? r_stop : w_sum_cur[STEP_W-1:0];
   assign w_turn_up   = (w_sum_start > {1'b0, r_stop}) ? r_stop : w_sum_start[STEP_W-1:0];
   // Distances are taken against f_start first, so neither subtraction can underflow.
   assign w_dn_next   = ((r_cur - r_start) < r_inc) ? r_start : (r_cur - r_inc);
   assign w_turn_dn   = ((r_stop - r_start) < r_inc) ? r_start : (r_stop - r_inc);

   always_comb begin
      w_state_d = r_state;
      w_cur_d   = r_cur;
      w_cnt_d   = r_cnt;
      w_mode_d  = r_mode;
      w_start_d = r_start;
      w_stop_d  = r_stop;
      w_inc_d   = r_inc;
      w_dwell_d = r_dwell;
      w_done_d  = 1'b0;
      w_wrap_d  = 1'b0;
      w_err_d   = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_cur_d = '0;
            w_cnt_d = '0;
            if (i_start && !i_abort) begin
               w_mode_d  = i_mode;
               w_start_d = i_f_start;
               w_stop_d  = i_f_stop;
               w_inc_d   = i_f_inc;
               w_dwell_d = i_dwell;
               if ((i_f_start > i_f_stop) || ((i_f_inc == '0) && (i_f_start != i_f_stop))) begin
                  w_err_d = 1'b1;
               end else begin
                  w_state_d = StRunUp;
                  w_cur_d   = i_f_start;
               end
            end
         end

         StRunUp, StRunDown: begin
            if (i_abort) begin
               w_state_d = StIdle;
               w_cur_d   = '0;
               w_cnt_d   = '0;
            end else if (r_cnt != r_dwell) begin
               w_cnt_d = r_cnt + 1'b1;
            end else begin
               w_cnt_d = '0;
               if (r_state == StRunDown) begin
                  if (r_cur == r_start) begin
                     w_state_d = StRunUp;
                     w_cur_d   = w_turn_up;
                     w_wrap_d  = 1'b1;
                  end else begin
                     w_cur_d = w_dn_next;
                  end
               end else if (r_cur == r_stop) begin
                  if (r_mode == ModeRepeat) begin
                     w_cur_d  = r_start;
                     w_wrap_d = 1'b1;
                  end else if (r_mode == ModePingPong) begin
                     w_state_d = StRunDown;
                     w_cur_d   = w_turn_dn;
                     w_wrap_d  = 1'b1;
                  end else begin
                     // Single and reserved mode both finish here.
                     w_state_d = StIdle;
                     w_cur_d   = '0;
                     w_done_d  = 1'b1;
                  end
               end else begin
                  w_cur_d = w_up_next;
               end
            end
         end

         default: begin
            w_state_d = StIdle;
            w_cur_d   = '0;
            w_cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_cur   <= '0;
         r_cnt   <= '0;
         r_mode  <= '0;
         r_start <= '0;
         r_stop  <= '0;
         r_inc   <= '0;
         r_dwell <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cur   <= w_cur_d;
         r_cnt   <= w_cnt_d;
         r_mode  <= w_mode_d;
         r_start <= w_start_d;
         r_stop  <= w_stop_d;
         r_inc   <= w_inc_d;
         r_dwell <= w_dwell_d;
         r_busy  <= (w_state_d != StIdle);
         r_done  <= w_done_d;
         r_wrap  <= w_wrap_d;
         r_err   <= w_err_d;
      end
   end

   assign o_phase_step = r_cur;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_wrap       = r_wrap;
   assign o_err        = r_err;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed self-checking bench for sweep_controller: one task per scenario, hand-computed vectors.
module tb_sweep_controller;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [1:0]  mode;
   logic [9:0]  f_start, f_stop, f_inc;
   logic [15:0] dwell;
   logic [9:0]  phase_step;
   logic        busy, done, wrap, err;

   int total = 0;
   int bad   = 0;

   sweep_controller #(.STEP_W(10), .DWELL_W(16)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .i_mode(mode),
      .i_f_start(f_start), .i_f_stop(f_stop), .i_f_inc(f_inc), .i_dwell(dwell),
      .o_phase_step(phase_step), .o_busy(busy), .o_done(done), .o_wrap(wrap), .o_err(err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [1:0] m, input int s, input int p, input int inc, input int d);
      mode = m; f_start = 10'(s); f_stop = 10'(p); f_inc = 10'(inc); dwell = 16'(d);
   endtask

   // Start sampled at edge N; returns in cycle N+1.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      setup(2'b00, 0, 0, 0, 0);
      tick(); tick();
      reset = 1'b0;
      total++;
      if (phase_step !== 10'd0 || busy !== 1'b0) begin
         $display("FAIL reset_data: phase=%0d busy=%b, required 0 0", phase_step, busy); bad++;
      end
      total++;
      if ({done, wrap, err} !== 3'b000) begin
         $display("FAIL reset_pulses: done/wrap/err=%b, required 000", {done, wrap, err}); bad++;
      end
   endtask

   task automatic test_single();
      int exp;
      setup(2'b00, 100, 130, 10, 2);
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         exp = 100 + 10 * (i / 3);
         total++;
         if (phase_step !== 10'(exp) || busy !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
            $display("FAIL single_seq[%0d]: phase=%0d busy=%b done=%b wrap=%b, required %0d 1 0 0",
                     i, phase_step, busy, done, wrap, exp);
            bad++;
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || phase_step !== 10'd0) begin
         $display("FAIL single_done: done=%b busy=%b phase=%0d, required 1 0 0",
                  done, busy, phase_step);
         bad++;
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         $display("FAIL single_done_width: done=%b, required 0", done); bad++;
      end
   endtask

   task automatic test_clamp();
      int exp_seq[4] = '{100, 110, 120, 125};
      setup(2'b00, 100, 125, 10, 0);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (phase_step !== 10'(exp_seq[i]) || done !== 1'b0) begin
            $display("FAIL clamp_seq[%0d]: phase=%0d done=%b, required %0d 0",
                     i, phase_step, done, exp_seq[i]);
            bad++;
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL clamp_done: done=%b busy=%b, required 1 0", done, busy); bad++;
      end
      tick();
   endtask

   task automatic test_pingpong();
      int exp_seq[9] = '{10, 20, 30, 20, 10, 20, 30, 20, 10};
      logic exp_wrap[9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
      setup(2'b10, 10, 30, 10, 0);
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         total++;
         if (phase_step !== 10'(exp_seq[i]) || wrap !== exp_wrap[i] || done !== 1'b0) begin
            $display("FAIL pingpong_seq[%0d]: phase=%0d wrap=%b done=%b, required %0d %b 0",
                     i, phase_step, wrap, done, exp_seq[i], exp_wrap[i]);
            bad++;
         end
         tick();
      end
      abort = 1'b1;
      // Last tick left phase_step at the value after index 8 (20); abort now.
      tick();
      abort = 1'b0;
      total++;
      if (phase_step !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
         $display("FAIL pingpong_abort: phase=%0d busy=%b done=%b wrap=%b, required 0 0 0 0",
                  phase_step, busy, done, wrap);
         bad++;
      end
      tick();
   endtask

   task automatic test_repeat();
      int exp_seq[13] = '{5, 5, 6, 6, 7, 7, 5, 5, 6, 6, 7, 7, 5};
      logic exp_wrap[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      setup(2'b01, 5, 7, 1, 1);
      pulse_start();
      f_stop = 10'd100;
      f_start = 10'd1;
      for (int i = 0; i < 13; i++) begin
         total++;
         if (phase_step !== 10'(exp_seq[i]) || wrap !== exp_wrap[i] || busy !== 1'b1) begin
            $display("FAIL repeat_seq[%0d]: phase=%0d wrap=%b busy=%b, required %0d %b 1",
                     i, phase_step, wrap, busy, exp_seq[i], exp_wrap[i]);
            bad++;
         end
         tick();
      end
      do_abort();
   endtask

   task automatic test_degenerate();
      logic exp_wrap[5] = '{0, 0, 1, 0, 1};
      setup(2'b00, 20, 20, 0, 1);
      pulse_start();
      tick();
      total++;
      if (phase_step !== 10'd20 || busy !== 1'b1) begin
         $display("FAIL degen_single_hold: phase=%0d busy=%b, required 20 1", phase_step, busy);
         bad++;
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         $display("FAIL degen_single_done: done=%b busy=%b err=%b, required 1 0 0",
                  done, busy, err);
         bad++;
      end
      setup(2'b10, 20, 20, 0, 1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (phase_step !== 10'd20 || wrap !== exp_wrap[i]) begin
            $display("FAIL degen_pp[%0d]: phase=%0d wrap=%b, required 20 %b",
                     i, phase_step, wrap, exp_wrap[i]);
            bad++;
         end
         tick();
      end
      do_abort();
   endtask

   task automatic test_reject();
      setup(2'b00, 50, 40, 1, 0);
      pulse_start();
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || phase_step !== 10'd0) begin
         $display("FAIL reject_order: err=%b busy=%b phase=%0d, required 1 0 0",
                  err, busy, phase_step);
         bad++;
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL reject_err_width: err=%b busy=%b, required 0 0", err, busy); bad++;
      end
      setup(2'b00, 10, 20, 0, 0);
      pulse_start();
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL reject_zero_inc: err=%b busy=%b, required 1 0", err, busy); bad++;
      end
      tick();
   endtask

   task automatic test_conflict();
      setup(2'b00, 100, 130, 10, 2);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      total++;
      if (busy !== 1'b0 || err !== 1'b0 || phase_step !== 10'd0) begin
         $display("FAIL start_abort: busy=%b err=%b phase=%0d, required 0 0 0",
                  busy, err, phase_step);
         bad++;
      end
      pulse_start();
      tick();
      setup(2'b01, 500, 600, 1, 0);
      pulse_start();
      total++;
      if (phase_step !== 10'd100 || busy !== 1'b1 || err !== 1'b0) begin
         $display("FAIL start_busy_hold: phase=%0d busy=%b err=%b, required 100 1 0",
                  phase_step, busy, err);
         bad++;
      end
      tick();
      total++;
      if (phase_step !== 10'd110) begin
         $display("FAIL start_busy_step: phase=%0d, required 110", phase_step); bad++;
      end
      do_abort();
   endtask

   task automatic test_reset_mid();
      setup(2'b10, 100, 130, 10, 2);
      pulse_start();
      tick(); tick(); tick(); tick();
      total++;
      if (phase_step !== 10'd110) begin
         $display("FAIL reset_mid_pre: phase=%0d, required 110", phase_step); bad++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (phase_step !== 10'd0 || {busy, done, wrap, err} !== 4'b0000) begin
         $display("FAIL reset_mid: phase=%0d busy/done/wrap/err=%b, required 0 0000",
                  phase_step, {busy, done, wrap, err});
         bad++;
      end
      setup(2'b00, 100, 125, 10, 0);
      pulse_start();
      tick();
      total++;
      if (phase_step !== 10'd110 || busy !== 1'b1) begin
         $display("FAIL reset_restart: phase=%0d busy=%b, required 110 1", phase_step, busy);
         bad++;
      end
      do_abort();
   endtask

   initial begin
      test_reset();
      test_single();
      test_clamp();
      test_pingpong();
      test_repeat();
      test_degenerate();
      test_reject();
      test_conflict();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
